// File: rtl/peripheral_mult_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : peripheral_mult_gen_if
//  Description : Bus bundle for the memory-mapped multiplier peripheral.
//                The master drives address, data and strobes; the slave
//                returns combinational read data.
//  Revision    : 1.0  initial release
// ============================================================================
interface peripheral_mult_gen_if #(
    parameter int ADDR_W = 5
) ();
    logic [31:0]       d_in;
    logic              cs;
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              wr;
    logic [31:0]       d_out;

    modport master (
        output d_in,
        output cs,
        output addr,
        output rd,
        output wr,
        input  d_out
    );

    modport slave (
        input  d_in,
        input  cs,
        input  addr,
        input  rd,
        input  wr,
        output d_out
    );
endinterface
`default_nettype wire

// File: rtl/peripheral_mult_gen.sv
`default_nettype none
// ============================================================================
//  Module      : peripheral_mult_gen
//  Description : Memory-mapped iterative radix-2 shift-add multiplier with
//                parametrised operand width, signed/unsigned mode and
//                busy/done status. Product is exposed as two 32-bit words.
//  Revision    : 1.0  initial release
// ============================================================================
module peripheral_mult_gen #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 5
) (
    input  wire logic             clk,
    input  wire logic             reset,
    peripheral_mult_gen_if.slave  bus
);

    localparam int PW      = 2 * WIDTH;
    localparam int CNT_W   = $clog2(WIDTH);

    localparam logic [CNT_W-1:0]  c_LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [ADDR_W-1:0] c_ADDR_A      = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] c_ADDR_B      = ADDR_W'(8'h08);
    localparam logic [ADDR_W-1:0] c_ADDR_CTRL   = ADDR_W'(8'h0C);
    localparam logic [ADDR_W-1:0] c_ADDR_RES_LO = ADDR_W'(8'h10);
    localparam logic [ADDR_W-1:0] c_ADDR_STATUS = ADDR_W'(8'h14);
    localparam logic [ADDR_W-1:0] c_ADDR_RES_HI = ADDR_W'(8'h18);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic             sgn_q,     sgn_d;
    logic [PW-1:0]    product_q, product_d;
    logic             done_q,    done_d;
    logic             busy_q,    busy_d;
    logic             neg_q,     neg_d;
    logic [PW-1:0]    ma_q,      ma_d;
    logic [WIDTH:0]   mb_q,      mb_d;
    logic [PW-1:0]    acc_q,     acc_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic w_wr_en;
    logic w_wr_a;
    logic w_wr_b;
    logic w_wr_ctrl;
    logic w_start;
    logic w_sgn_new;

    assign w_wr_en   = bus.cs & bus.wr;
    assign w_wr_a    = w_wr_en && (bus.addr == c_ADDR_A);
    assign w_wr_b    = w_wr_en && (bus.addr == c_ADDR_B);
    assign w_wr_ctrl = w_wr_en && (bus.addr == c_ADDR_CTRL);
    // A start is only accepted from IDLE; a start while busy is dropped.
    assign w_start   = w_wr_ctrl && bus.d_in[0] && (state_q == c_IDLE);
    // The start write carries the mode for the operation it launches.
    assign w_sgn_new = bus.d_in[1];

    // Reads have no side effects; rd and the upper write-data bits are
    // intentionally not used by the logic.
    logic w_unused;
    assign w_unused = &{1'b0, bus.rd, bus.d_in};

    // ------------------------------------------------------------------
    // Operand magnitudes, formed in WIDTH+1 bits so that the most negative
    // value has a representable magnitude.
    // ------------------------------------------------------------------
    logic [WIDTH:0] w_a_ext;
    logic [WIDTH:0] w_b_ext;
    logic [WIDTH:0] w_a_abs;
    logic [WIDTH:0] w_b_abs;

    assign w_a_ext = {w_sgn_new & a_q[WIDTH-1], a_q};
    assign w_b_ext = {w_sgn_new & b_q[WIDTH-1], b_q};
    assign w_a_abs = w_a_ext[WIDTH] ? (~w_a_ext + 1'b1) : w_a_ext;
    assign w_b_abs = w_b_ext[WIDTH] ? (~w_b_ext + 1'b1) : w_b_ext;

    // State register: all flops, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= c_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            neg_q     <= 1'b0;
            ma_q      <= '0;
            mb_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sgn_q     <= sgn_d;
            product_q <= product_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            neg_q     <= neg_d;
            ma_q      <= ma_d;
            mb_q      <= mb_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic: fixed WIDTH iterations in CALC, one cycle in FIX
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (w_start) state_d = c_CALC;
            c_CALC:  if (cnt_q == c_LAST_ITER) state_d = c_FIX;
            c_FIX:   state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // Register-file writes and shift-add datapath per state
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        product_d = product_q;
        done_d    = done_q;
        busy_d    = busy_q;
        neg_d     = neg_q;
        ma_d      = ma_q;
        mb_d      = mb_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;

        // Operand/mode registers are writable at any time; the running
        // operation works from its own captured copies.
        if (w_wr_a)    a_d   = bus.d_in[WIDTH-1:0];
        if (w_wr_b)    b_d   = bus.d_in[WIDTH-1:0];
        if (w_wr_ctrl) sgn_d = bus.d_in[1];

        case (state_q)
            c_IDLE: begin
                if (w_start) begin
                    ma_d   = {{(WIDTH-1){1'b0}}, w_a_abs};
                    mb_d   = w_b_abs;
                    neg_d  = w_sgn_new & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    acc_d  = '0;
                    cnt_d  = '0;
                    done_d = 1'b0;
                    busy_d = 1'b1;
                end
            end
            c_CALC: begin
                // Shifting ma left each step is equivalent to ma << cnt.
                if (mb_q[0]) acc_d = acc_q + ma_q;
                ma_d  = ma_q << 1;
                mb_d  = mb_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
            end
            c_FIX: begin
                product_d = neg_q ? (~acc_q + 1'b1) : acc_q;
                done_d    = 1'b1;
                busy_d    = 1'b0;
            end
            default: ;
        endcase
    end

    // Read mux: product zero-extended to 64 bits feeds both result words
    logic [63:0] w_prod_ext;
    logic [31:0] w_d_out;

    assign w_prod_ext = 64'(product_q);

    always_comb begin
        w_d_out = 32'h0;
        if (bus.cs) begin
            case (bus.addr)
                c_ADDR_RES_LO: w_d_out = w_prod_ext[31:0];
                c_ADDR_STATUS: w_d_out = {30'h0, busy_q, done_q};
                c_ADDR_RES_HI: w_d_out = w_prod_ext[63:32];
                default:       w_d_out = 32'h0;
            endcase
        end
    end

    assign bus.d_out = w_d_out;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_mult_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_peripheral_mult_gen
//  Description : Directed bench for peripheral_mult_gen; a WIDTH=16 and a
//                WIDTH=32 instance share the same bus stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_peripheral_mult_gen;

    localparam logic [4:0] c_A      = 5'h04;
    localparam logic [4:0] c_B      = 5'h08;
    localparam logic [4:0] c_CTRL   = 5'h0C;
    localparam logic [4:0] c_RES_LO = 5'h10;
    localparam logic [4:0] c_STATUS = 5'h14;
    localparam logic [4:0] c_RES_HI = 5'h18;
    localparam logic [4:0] c_UNMAP  = 5'h1C;

    logic        clk;
    logic        reset;
    logic [31:0] d_in;
    logic        cs;
    logic [4:0]  addr;
    logic        rd;
    logic        wr;

    int n_checks = 0;
    int n_pass   = 0;

    peripheral_mult_gen_if #(.ADDR_W(5)) bus16 ();
    peripheral_mult_gen_if #(.ADDR_W(5)) bus32 ();

    assign bus16.d_in = d_in;
    assign bus16.cs   = cs;
    assign bus16.addr = addr;
    assign bus16.rd   = rd;
    assign bus16.wr   = wr;
    assign bus32.d_in = d_in;
    assign bus32.cs   = cs;
    assign bus32.addr = addr;
    assign bus32.rd   = rd;
    assign bus32.wr   = wr;

    peripheral_mult_gen #(.WIDTH(16), .ADDR_W(5)) u_dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16.slave)
    );

    peripheral_mult_gen #(.WIDTH(32), .ADDR_W(5)) u_dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bounded run time; an expired bound is reported and stops the run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    endtask

    // One write: strobes asserted from negedge through the next posedge
    task automatic bus_write(input logic [4:0] a, input logic [31:0] data);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; d_in = data;
        @(posedge clk);
        #1;
        cs = 1'b0; wr = 1'b0; d_in = 32'h0;
    endtask

    // Combinational read from one instance, compared against expectation
    task automatic check_reg(input string tag, input bit sel32, input logic [4:0] a,
                             input logic [31:0] exp);
        logic [31:0] got;
        cs = 1'b1; rd = 1'b1; addr = a;
        #1;
        got = sel32 ? bus32.d_out : bus16.d_out;
        cs = 1'b0; rd = 1'b0;
        check_val(tag, got, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] got;
        reset = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; d_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset state
        check_reg("rst_status16", 1'b0, c_STATUS, 32'h0);
        check_reg("rst_reslo16",  1'b0, c_RES_LO, 32'h0);
        check_reg("rst_reshi32",  1'b1, c_RES_HI, 32'h0);

        // T1: 3*5 unsigned, exact latency of WIDTH+1 cycles
        bus_write(c_A, 32'd3);
        bus_write(c_B, 32'd5);
        bus_write(c_CTRL, 32'h1);
        check_reg("t1_busy_e0",   1'b0, c_STATUS, 32'h2);
        cycles(16);
        check_reg("t1_busy_e16",  1'b0, c_STATUS, 32'h2);
        cycles(1);
        check_reg("t1_done_e17",  1'b0, c_STATUS, 32'h1);
        check_reg("t1_reslo16",   1'b0, c_RES_LO, 32'd15);
        cycles(20);
        check_reg("t1_reslo32",   1'b1, c_RES_LO, 32'd15);
        check_reg("t1_sticky16",  1'b0, c_STATUS, 32'h1);

        // T2: 0xFFFF squared, unsigned
        bus_write(c_A, 32'hFFFF);
        bus_write(c_B, 32'hFFFF);
        bus_write(c_CTRL, 32'h1);
        cycles(17);
        check_reg("t2_reslo16",   1'b0, c_RES_LO, 32'hFFFE0001);
        check_reg("t2_reshi16",   1'b0, c_RES_HI, 32'h0);
        cycles(20);
        check_reg("t2_reshi32",   1'b1, c_RES_HI, 32'h0);

        // T3: signed, mode set before the start write
        bus_write(c_CTRL, 32'h2);
        bus_write(c_A, 32'hFFFF);
        bus_write(c_B, 32'h0002);
        bus_write(c_CTRL, 32'h3);
        cycles(17);
        check_reg("t3_neg_lo16",  1'b0, c_RES_LO, 32'hFFFFFFFE);
        check_reg("t3_neg_hi16",  1'b0, c_RES_HI, 32'h0);
        cycles(20);
        bus_write(c_A, 32'h8000);
        bus_write(c_B, 32'h8000);
        bus_write(c_CTRL, 32'h3);
        cycles(17);
        check_reg("t3_min_lo16",  1'b0, c_RES_LO, 32'h40000000);
        check_reg("t3_min_st16",  1'b0, c_STATUS, 32'h1);
        cycles(20);

        // T4: WIDTH=32 all-ones squared, 33-cycle latency
        bus_write(c_CTRL, 32'h0);
        bus_write(c_A, 32'hFFFFFFFF);
        bus_write(c_B, 32'hFFFFFFFF);
        bus_write(c_CTRL, 32'h1);
        check_reg("t4_clr_done32", 1'b1, c_STATUS, 32'h2);
        cycles(32);
        check_reg("t4_busy_e32",  1'b1, c_STATUS, 32'h2);
        cycles(1);
        check_reg("t4_done_e33",  1'b1, c_STATUS, 32'h1);
        check_reg("t4_reshi32",   1'b1, c_RES_HI, 32'hFFFFFFFE);
        check_reg("t4_reslo32",   1'b1, c_RES_LO, 32'h00000001);
        cycles(5);

        // T5: start while busy is ignored; A write while busy is stored
        bus_write(c_A, 32'd2);
        bus_write(c_B, 32'd3);
        bus_write(c_CTRL, 32'h1);
        cycles(3);
        bus_write(c_A, 32'd7);
        bus_write(c_CTRL, 32'h1);
        check_reg("t5_old_prod",  1'b0, c_RES_LO, 32'hFFFE0001);
        cycles(11);
        check_reg("t5_busy_e16",  1'b0, c_STATUS, 32'h2);
        cycles(1);
        check_reg("t5_done_e17",  1'b0, c_STATUS, 32'h1);
        check_reg("t5_reslo16",   1'b0, c_RES_LO, 32'd6);
        cycles(20);
        bus_write(c_CTRL, 32'h1);
        cycles(17);
        check_reg("t5_newa_lo16", 1'b0, c_RES_LO, 32'd21);

        // Unmapped address and deselected reads return zero
        check_reg("unmapped_rd",  1'b0, c_UNMAP, 32'h0);
        cs = 1'b0; addr = c_RES_LO;
        #1;
        got = bus16.d_out;
        check_val("cs_low_rd", got, 32'h0);
        cycles(20);

        // T6: reset in the middle of a run
        bus_write(c_CTRL, 32'h1);
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reg("t6_status16",  1'b0, c_STATUS, 32'h0);
        check_reg("t6_reslo16",   1'b0, c_RES_LO, 32'h0);
        cycles(20);
        check_reg("t6_nodone16",  1'b0, c_STATUS, 32'h0);
        check_reg("t6_status32",  1'b1, c_STATUS, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
